// File: rtl/des_pkg.sv
// Shared tables and types for the DES round-function contraction stage:
// the eight S-boxes, the P permutation and the engine state encoding.
package des_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

   // Indexed [box][{row, col}], row = {b1,b6}, col = {b2..b5}.
   localparam int SBOX [8][64] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
   };

   // Output bit i+1 takes input bit P_TABLE[i] (DES numbering, bit 1 = MSB).
   localparam int P_TABLE [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
   };

   function automatic logic [1:32] p_perm(input logic [1:32] a);
      logic [1:32] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i+1] = a[P_TABLE[i]];
      end
      return r;
   endfunction

endpackage

// File: rtl/des_sbox.sv
// One DES S-box lookup; sel picks S1..S8 (0..7), six_bits is b1..b6.
module des_sbox
   import des_pkg::*;
(
   input  logic [2:0] sel,
   input  logic [1:6] six_bits,
   output logic [1:4] four_bits
);

   logic [5:0] w_idx;

   assign w_idx     = {six_bits[1], six_bits[6], six_bits[2:5]};
   assign four_bits = 4'(SBOX[sel][w_idx]);

endmodule

// File: rtl/des_sp_engine.sv
// Multi-cycle S-box + P contraction of the DES f function, 48 -> 32 bits,
// evaluating SBOX_PER_CYCLE S-boxes per clock behind valid/ready handshakes.
module des_sp_engine
   import des_pkg::*;
#(
   parameter int SBOX_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:48] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:32] out_data,
   output logic        busy
);

   localparam int             NUM_STEPS = 8 / SBOX_PER_CYCLE;
   localparam int             GW        = 6 * SBOX_PER_CYCLE;
   localparam int             OW        = 4 * SBOX_PER_CYCLE;
   localparam logic [2:0]     LAST_STEP = 3'(NUM_STEPS - 1);

   if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 &&
       SBOX_PER_CYCLE != 4 && SBOX_PER_CYCLE != 8) begin : g_bad_spc
      $error("des_sp_engine: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
   end

   state_e        r_state;
   logic [2:0]    r_step;
   logic [47:0]   r_sr;
   logic [31:0]   r_acc;
   logic [1:32]   r_out;

   logic [OW-1:0] w_new;
   logic [31:0]   w_acc_next;
   logic [47:0]   w_sr_next;

   // Group k always sits at the top of the shift register, left to right.
   for (genvar k = 0; k < SBOX_PER_CYCLE; k++) begin : g_sbox
      logic [2:0] w_sel;
      assign w_sel = 3'(int'(r_step) * SBOX_PER_CYCLE + k);
      des_sbox u_sbox (
         .sel       (w_sel),
         .six_bits  (r_sr[47-6*k -: 6]),
         .four_bits (w_new[OW-1-4*k -: 4])
      );
   end

   // Shifts by a full register width (SBOX_PER_CYCLE=8) yield zero, as intended.
   assign w_acc_next = (r_acc << OW) | 32'(w_new);
   assign w_sr_next  = r_sr << GW;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_step  <= '0;
         r_sr    <= '0;
         r_acc   <= '0;
         r_out   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_sr    <= in_data;
                  r_acc   <= '0;
                  r_step  <= '0;
                  r_state <= ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               r_sr  <= w_sr_next;
               r_acc <= w_acc_next;
               if (r_step == LAST_STEP) begin
                  r_out   <= p_perm(w_acc_next);
                  r_state <= ST_DONE;
               end else begin
                  r_step <= r_step + 3'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);
   assign out_data  = r_out;

endmodule

// File: tb/tb_des_sp_engine.sv
// Bench for des_sp_engine: four instances (1, 2, 4, 8 S-boxes per cycle),
// table vectors with a scoreboard, plus backpressure/back-to-back/reset sequences.
module tb_des_sp_engine;

   typedef struct {
      logic [1:48] din;
      logic [1:32] dout;
   } vec_t;

   typedef struct {
      logic [1:32] dout;
      int          hs;
   } exp_t;

   localparam logic [1:48] REF_IN   = 48'h6117BA866527;
   localparam logic [1:32] REF_OUT  = 32'h234AA9BB;
   localparam logic [1:48] ZERO_IN  = 48'h000000000000;
   localparam logic [1:32] ZERO_OUT = 32'hD8D8DBBC;

   // Rows of 16 nibbles, index box*4 + row, leftmost nibble is column 0.
   logic [63:0] tb_s [32] = '{
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
   };
   int tb_p [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

   logic        clk;
   logic        rst = 1'b1;
   logic [3:0]  in_valid_v;
   logic [3:0]  in_ready_v;
   logic [3:0]  out_valid_v;
   logic [3:0]  out_ready_v;
   logic [3:0]  busy_v;
   logic [1:48] in_data_v [4];
   logic [1:32] out_data_v [4];

   exp_t sbq [4][$];
   int   last_out_hs [4];
   logic [3:0] prev_ov = '0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      des_sp_engine #(.SBOX_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid_v[g]),
         .in_ready  (in_ready_v[g]),
         .in_data   (in_data_v[g]),
         .out_valid (out_valid_v[g]),
         .out_ready (out_ready_v[g]),
         .out_data  (out_data_v[g]),
         .busy      (busy_v[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running, required completion");
      $fatal(1, "simulation timeout");
   end

   function automatic logic [3:0] tb_sbox(input int box, input logic [5:0] v);
      int row;
      int col;
      row = int'({v[5], v[0]});
      col = int'(v[4:1]);
      return tb_s[box*4 + row][63 - 4*col -: 4];
   endfunction

   function automatic logic [31:0] tb_f(input logic [47:0] d);
      logic [31:0] s;
      logic [31:0] r;
      for (int j = 0; j < 8; j++) s[31 - 4*j -: 4] = tb_sbox(j, d[47 - 6*j -: 6]);
      for (int i = 0; i < 32; i++) r[31 - i] = s[32 - tb_p[i]];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic send(input int u, input logic [1:48] d, input logic [1:32] e, output int hs);
      int   n;
      exp_t x;
      n  = 0;
      hs = -1;
      in_data_v[u]  = d;
      in_valid_v[u] = 1'b1;
      while (hs < 0 && n < 100) begin
         @(negedge clk);
         if (in_ready_v[u]) begin
            hs     = cyc + 1;
            x.dout = e;
            x.hs   = hs;
            sbq[u].push_back(x);
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid_v[u] = 1'b0;
      if (hs < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_u%0d: in_ready never seen, required acceptance", u);
      end
   endtask

   task automatic drain(input int u);
      int n;
      n = 0;
      while (sbq[u].size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (sbq[u].size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_u%0d: %0d results outstanding, required 0", u, sbq[u].size());
         sbq[u].delete();
      end
   endtask

   task automatic wait_ov(input int u);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid_v[u] && n < 40);
      if (!out_valid_v[u]) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_out_valid_u%0d: out_valid=0, required 1", u);
      end
   endtask

   // Scoreboard monitor: latency on out_valid rise, data on output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int u = 0; u < 4; u++) begin
            if (out_valid_v[u] && !prev_ov[u]) begin
               if (sbq[u].size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL spurious_out_u%0d: out_valid=1, required no output", u);
               end else begin
                  chk($sformatf("latency_u%0d", u), 64'(cyc - sbq[u][0].hs), 64'(8 >> u));
               end
            end
            if (out_valid_v[u] && out_ready_v[u] && sbq[u].size() != 0) begin
               e = sbq[u].pop_front();
               chk($sformatf("out_data_u%0d", u), 64'(out_data_v[u]), 64'(e.dout));
               last_out_hs[u] = cyc + 1;
            end
            prev_ov[u] = out_valid_v[u];
         end
      end
   end

   initial begin
      vec_t vecs [$];
      vec_t v;
      int   hs;
      int   h1;
      int   h2;

      in_valid_v  = '0;
      out_ready_v = 4'hF;
      for (int u = 0; u < 4; u++) in_data_v[u] = '0;

      repeat (3) @(negedge clk);
      for (int u = 0; u < 4; u++) begin
         chk($sformatf("rst_in_ready_u%0d", u), 64'(in_ready_v[u]), 64'd1);
         chk($sformatf("rst_out_valid_u%0d", u), 64'(out_valid_v[u]), 64'd0);
         chk($sformatf("rst_busy_u%0d", u), 64'(busy_v[u]), 64'd0);
         chk($sformatf("rst_out_data_u%0d", u), 64'(out_data_v[u]), 64'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;

      v.din = REF_IN;  v.dout = REF_OUT;  vecs.push_back(v);
      v.din = ZERO_IN; v.dout = ZERO_OUT; vecs.push_back(v);
      for (int j = 0; j < 8; j++) begin
         for (int val = 0; val < 64; val++) begin
            v.din  = 48'(val) << (6 * (7 - j));
            v.dout = tb_f(v.din);
            vecs.push_back(v);
         end
      end
      foreach (vecs[i]) send(0, vecs[i].din, vecs[i].dout, hs);
      drain(0);

      for (int u = 1; u < 4; u++) begin
         send(u, ZERO_IN, ZERO_OUT, hs);
         send(u, REF_IN, REF_OUT, hs);
         drain(u);
      end

      // Backpressure: output held, stray in_valid pulse must be dropped.
      out_ready_v[0] = 1'b0;
      send(0, REF_IN, REF_OUT, hs);
      wait_ov(0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         in_data_v[0]  = ZERO_IN;
         in_valid_v[0] = (c == 1);
         @(negedge clk);
         chk("bp_out_data", 64'(out_data_v[0]), 64'(REF_OUT));
         chk("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
      end
      @(posedge clk);
      #1 out_ready_v[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_idle_in_ready", 64'(in_ready_v[0]), 64'd1);
      chk("bp_idle_out_valid", 64'(out_valid_v[0]), 64'd0);
      chk("bp_idle_busy", 64'(busy_v[0]), 64'd0);
      chk("bp_hold_out_data", 64'(out_data_v[0]), 64'(REF_OUT));
      repeat (10) @(negedge clk);
      chk("bp_pulse_ignored", 64'(busy_v[0]), 64'd0);
      @(posedge clk);
      #1;

      send(0, REF_IN, REF_OUT, h1);
      send(0, ZERO_IN, ZERO_OUT, h2);
      chk("b2b_accept_gap", 64'(h2 - last_out_hs[0]), 64'd1);
      chk("b2b_period", 64'(h2 - h1), 64'd10);
      drain(0);

      // Asynchronous reset at step 3 discards the block in flight.
      send(0, REF_IN, REF_OUT, hs);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_busy", 64'(busy_v[0]), 64'd1);
      chk("mid_in_ready", 64'(in_ready_v[0]), 64'd0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid_v[0]), 64'd0);
      chk("arst_in_ready", 64'(in_ready_v[0]), 64'd1);
      chk("arst_busy", 64'(busy_v[0]), 64'd0);
      sbq[0].delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(0, REF_IN, REF_OUT, hs);
      drain(0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
